// File: rtl/uart_tx_framer.sv
//------------------------------------------------------------------------------
// uart_tx_framer
//
// Transmit side of the 17-bit tagged-byte UART link. Each accepted 17-bit word
// is split into three alignment-tagged bytes:
//   B1 = {2'b00,  d[5:0]}
//   B2 = {2'b01,  d[11:6]}
//   B3 = {3'b100, d[16:12]}
// The bytes are sent back-to-back as 8N1 UART. The baud counter and the bit
// sequencing are built in, so no separate UART primitive is needed.
//
// Optional feature (macro INTER_FRAME_GAP_EN): after the B3 stop bit, the line
// is held idle-high for GAP_BITS extra bit periods before the next word is
// accepted. This gives the far-end assembler more margin to resynchronise.
//
// Ports:
//   clk_in      - system clock (single clock domain)
//   rst_in      - asynchronous reset, active low
//   data_in     - 17-bit word to send
//   valid_in    - data_in is valid
//   ready_out   - a word can be accepted this cycle (IDLE only)
//   tx_wire_out - registered UART serial line, idle high
//   busy_out    - a frame (or inter-frame gap) is in progress
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_framer #(
  parameter int INPUT_CLOCK_FREQ = 200_000_000,
  parameter int BAUD_RATE        = 115200,
  parameter int GAP_BITS         = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [16:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        tx_wire_out,
  output logic        busy_out
);

  localparam int BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W = (BAUD_BIT_PERIOD > 1) ? $clog2(BAUD_BIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_BIT_PERIOD - 1);
  // Bit index 0 is the start bit, 1..8 the data bits, 9 the stop bit.
  localparam logic [3:0] BIT_LAST = 4'd9;

`ifdef INTER_FRAME_GAP_EN
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);
`endif

  typedef enum logic [2:0] {
`ifdef INTER_FRAME_GAP_EN
    GAP,
`endif
    IDLE,
    SEND_B1,
    SEND_B2,
    SEND_B3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic [16:0]       word_q, word_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
`ifdef INTER_FRAME_GAP_EN
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
`endif

  // Tagged byte that the given SEND state transmits.
  function automatic logic [7:0] byte_of(input state_t s, input logic [16:0] w);
    logic [7:0] b;
    case (s)
      SEND_B1: b = {2'b00, w[5:0]};
      SEND_B2: b = {2'b01, w[11:6]};
      SEND_B3: b = {3'b100, w[16:12]};
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  // Line level for a given state and bit index; computed from the *next*
  // state so the registered line lines up with the state it belongs to.
  function automatic logic line_level(input state_t s, input logic [3:0] idx,
                                      input logic [16:0] w);
    logic [7:0] b;
    logic       lvl;
    b = byte_of(s, w);
    if (s != SEND_B1 && s != SEND_B2 && s != SEND_B3) begin
      lvl = 1'b1;
    end else if (idx == 4'd0) begin
      lvl = 1'b0;
    end else if (idx >= BIT_LAST) begin
      lvl = 1'b1;
    end else begin
      lvl = b[3'(idx - 4'd1)];
    end
    return lvl;
  endfunction

  // State, counters and output registers. Reset returns the line high at
  // once, so a frame interrupted by reset leaves no partial stop bit.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      word_q     <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b0;
`ifdef INTER_FRAME_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      word_q     <= word_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
`ifdef INTER_FRAME_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  // Next-state logic. The baud counter runs in every non-IDLE state; each
  // wrap advances the bit index, and the stop-bit wrap moves on to the next
  // byte with its start bit immediately, so bytes are back-to-back.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    word_d     = word_q;
`ifdef INTER_FRAME_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (valid_in && ready_q) begin
          state_d    = SEND_B1;
          word_d     = data_in;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
        end
      end

      SEND_B1, SEND_B2, SEND_B3: begin
        if (baud_cnt_q == CNT_LAST) begin
          baud_cnt_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = '0;
            if (state_q == SEND_B1) begin
              state_d = SEND_B2;
            end else if (state_q == SEND_B2) begin
              state_d = SEND_B3;
            end else begin
`ifdef INTER_FRAME_GAP_EN
              state_d   = GAP;
              gap_cnt_d = '0;
`else
              state_d   = IDLE;
`endif
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

`ifdef INTER_FRAME_GAP_EN
      GAP: begin
        if (baud_cnt_q == CNT_LAST) begin
          baud_cnt_d = '0;
          if (gap_cnt_q == GAP_LAST) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    tx_d    = line_level(state_d, bit_idx_d, word_d);
    ready_d = (state_d == IDLE);
  end

  assign ready_out   = ready_q;
  assign tx_wire_out = tx_q;
  assign busy_out    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_framer.sv
//------------------------------------------------------------------------------
// tb_uart_tx_framer
//
// Self-checking bench for uart_tx_framer at 16 clock cycles per bit.
// Expected line waveforms and byte values come from a reference model that
// works directly from the byte-tagging arithmetic and 8N1 bit timing.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx_framer;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int GAP_BITS = 2;
  localparam int P        = CLK_FREQ / BAUD;
  localparam int FRAME    = 30 * P;
`ifdef INTER_FRAME_GAP_EN
  localparam int GAP_CYCLES = GAP_BITS * P;
`else
  localparam int GAP_CYCLES = 0;
`endif

  typedef struct {
    logic [16:0] data;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
  } vector_t;

  logic        clk_in   = 1'b0;
  logic        rst_in   = 1'b0;
  logic [16:0] data_in  = '0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        tx_wire_out;
  logic        busy_out;

  int assertCount = 0;
  int failCount   = 0;

  uart_tx_framer #(
    .INPUT_CLOCK_FREQ(CLK_FREQ),
    .BAUD_RATE(BAUD),
    .GAP_BITS(GAP_BITS)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .data_in(data_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .tx_wire_out(tx_wire_out),
    .busy_out(busy_out)
  );

  // Free-running clock, 10 ns period.
  always #5 clk_in = ~clk_in;

  // Hard stop in case something never returns.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Reference encoding: split the word into 6/6/5-bit fields and add tags.
  function automatic logic [23:0] encodeWord(input int d);
    int b1, b2, b3;
    b1 = d % 64;
    b2 = 64 + (d / 64) % 64;
    b3 = 128 + d / 4096;
    return {8'(b1), 8'(b2), 8'(b3)};
  endfunction

  // Expected line level k cycles after the start of a frame.
  function automatic logic expectedLevel(input logic [23:0] bytes, input int k);
    int b, j, bv;
    b  = k / (10 * P);
    j  = (k / P) % 10;
    bv = int'((bytes >> (8 * (2 - b))) & 24'hFF);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return 1'((bv >> (j - 1)) & 1);
  endfunction

  // Wait for ready, hand over one word, then follow the whole frame checking
  // the line, busy and ready every cycle and decoding bytes at mid-bit.
  task automatic applyStimulus(input logic [16:0] d, input logic [23:0] expBytes,
                               input string name, input bit holdValid,
                               input logic [16:0] nextData, input bit noise,
                               output int waited);
    int lineErr, busyErr, lowCount, gapErr, j;
    logic [7:0] decoded [3];
    waited = 0;
    while (ready_out !== 1'b1 && waited < 2000) begin
      @(negedge clk_in);
      waited++;
    end
    if (ready_out !== 1'b1) begin
      checkOutput({name, " readyTimeout"}, 0, 1);
      return;
    end
    data_in  = d;
    valid_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    if (holdValid) data_in = nextData;
    else           valid_in = 1'b0;

    lineErr = 0; busyErr = 0; lowCount = 0; gapErr = 0;
    for (int i = 0; i < 3; i++) decoded[i] = '0;
    for (int k = 0; k < FRAME; k++) begin
      if (tx_wire_out !== expectedLevel(expBytes, k)) lineErr++;
      if (busy_out !== 1'b1) busyErr++;
      if (ready_out === 1'b0) lowCount++;
      j = (k / P) % 10;
      if ((k % P) == P / 2 && j >= 1 && j <= 8)
        decoded[k / (10 * P)][j - 1] = tx_wire_out;
      if (noise) begin
        if (k < FRAME - 1) begin
          valid_in = 1'($urandom_range(0, 1));
          data_in  = 17'($urandom);
        end else begin
          valid_in = 1'b0;
        end
      end
      @(negedge clk_in);
    end
    checkOutput({name, " lineErrors"}, lineErr, 0);
    checkOutput({name, " busyErrors"}, busyErr, 0);
    checkOutput({name, " readyLowCycles"}, lowCount, FRAME);
    checkOutput({name, " byte1"}, int'(decoded[0]), int'(expBytes[23:16]));
    checkOutput({name, " byte2"}, int'(decoded[1]), int'(expBytes[15:8]));
    checkOutput({name, " byte3"}, int'(decoded[2]), int'(expBytes[7:0]));

    if (GAP_CYCLES > 0) begin
      for (int k = 0; k < GAP_CYCLES; k++) begin
        if (tx_wire_out !== 1'b1 || busy_out !== 1'b1 || ready_out !== 1'b0) gapErr++;
        @(negedge clk_in);
      end
      checkOutput({name, " gapErrors"}, gapErr, 0);
    end

    checkOutput({name, " readyAfter"}, int'(ready_out), 1);
    checkOutput({name, " busyAfter"}, int'(busy_out), 0);
    checkOutput({name, " txAfter"}, int'(tx_wire_out), 1);
  endtask

  initial begin
    vector_t vectors [4];
    int waited;
    int idleErr;
    logic [16:0] d;

    vectors[0] = '{data: 17'h12345, b1: 8'h05, b2: 8'h4D, b3: 8'h92};
    vectors[1] = '{data: 17'h1FFFF, b1: 8'h3F, b2: 8'h7F, b3: 8'h9F};
    vectors[2] = '{data: 17'h00000, b1: 8'h00, b2: 8'h40, b3: 8'h80};
    vectors[3] = '{data: 17'h0AAAA, b1: 8'h2A, b2: 8'h6A, b3: 8'h8A};

    // Reset state, with clock edges occurring while reset is held.
    repeat (3) @(negedge clk_in);
    checkOutput("resetTx", int'(tx_wire_out), 1);
    checkOutput("resetReady", int'(ready_out), 0);
    checkOutput("resetBusy", int'(busy_out), 0);
    rst_in = 1'b1;
    #1;
    checkOutput("readyBeforeEdge", int'(ready_out), 0);
    @(negedge clk_in);
    checkOutput("readyAfterRelease", int'(ready_out), 1);

    // Table-driven frames with hand-computed byte values.
    $display("[TB] table vectors");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vectors[i].data, {vectors[i].b1, vectors[i].b2, vectors[i].b3},
                    $sformatf("vec%0d", i), 1'b0, '0, 1'b0, waited);
    end

    // Back-to-back with valid held: next start bit after exactly one idle cycle.
    $display("[TB] back-to-back");
    applyStimulus(17'h1FFFF, 24'h3F7F9F, "b2bFirst", 1'b1, 17'h00000, 1'b0, waited);
    applyStimulus(17'h00000, 24'h004080, "b2bSecond", 1'b0, '0, 1'b0, waited);
    checkOutput("b2bWaitCycles", waited, 0);

    // valid_in toggled with random data while busy must not queue anything.
    $display("[TB] valid noise while busy");
    applyStimulus(17'h0F0F0, encodeWord(32'h0F0F0), "noise", 1'b0, '0, 1'b1, waited);
    idleErr = 0;
    for (int k = 0; k < 3 * P; k++) begin
      if (tx_wire_out !== 1'b1 || busy_out !== 1'b0) idleErr++;
      @(negedge clk_in);
    end
    checkOutput("noiseNoExtraFrame", idleErr, 0);

    // Reset 200 cycles into a frame (B2 data bit 1, which is a zero).
    $display("[TB] mid-frame reset");
    data_in  = 17'h12345;
    valid_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    valid_in = 1'b0;
    repeat (200) @(negedge clk_in);
    checkOutput("preResetTx", int'(tx_wire_out), 0);
    checkOutput("preResetBusy", int'(busy_out), 1);
    #2;
    rst_in = 1'b0;
    #1;
    checkOutput("abortTx", int'(tx_wire_out), 1);
    checkOutput("abortBusy", int'(busy_out), 0);
    checkOutput("abortReady", int'(ready_out), 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    checkOutput("abortReadyNoEdge", int'(ready_out), 0);
    @(posedge clk_in);
    #1;
    checkOutput("abortReadyOneEdge", int'(ready_out), 1);
    @(negedge clk_in);
    applyStimulus(17'h0ABCD, encodeWord(32'h0ABCD), "postReset", 1'b0, '0, 1'b0, waited);

    // Random words against the reference model.
    $display("[TB] random words");
    for (int i = 0; i < 8; i++) begin
      d = 17'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk_in);
      applyStimulus(d, encodeWord(int'(d)), $sformatf("rand%0d", i), 1'b0, '0, 1'b0, waited);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Transmit-side counterpart of the 17-bit tagged-byte UART link, located on the sending FPGA.
- Accepts one 17-bit word per valid/ready handshake and splits it into three alignment-tagged bytes.
- Serialises the bytes as 8N1 UART on a single wire; the 3-byte receive assembler on the far FPGA consumes this stream.
- Contains its own baud counter and bit shifter, so no separate UART transmit primitive is instantiated.

Parameters:
- INPUT_CLOCK_FREQ, 200_000_000: clk_in frequency in Hz.
- BAUD_RATE, 115200: line rate. Bit period BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE, integer division, so 1736 cycles at the defaults.
- GAP_BITS, 2: idle bit periods inserted after each frame; used only when INTER_FRAME_GAP_EN is defined.

Ports:
- clk_in  input  1  system clock (one clock domain only).
- rst_in  input  1  reset, asynchronous and active-low.
- data_in  input  17  word to send.
- valid_in  input  1  data_in is valid.
- ready_out  output  1  block can accept a word this cycle.
- tx_wire_out  output  1  UART serial line, idle high.
- busy_out  output  1  a frame is in progress.

Behaviour:
- Reset (rst_in low, asynchronous):
  - state = IDLE; tx_wire_out = 1; ready_out = 0; busy_out = 0; all counters and the latched word are 0.
  - ready_out rises on the first clk_in edge after rst_in deasserts.
  - Reset asserted mid-frame aborts the frame immediately: the line returns high with no partial stop bit.
- Handshake:
  - A transfer occurs on a rising edge where valid_in and ready_out are both 1. data_in is latched on that edge.
  - ready_out is 1 only in IDLE. It drops on the edge after acceptance.
  - valid_in while ready_out = 0 is ignored; the word is not queued.
- Byte encoding, from the latched word d:
  - B1 = {2'b00, d[5:0]}
  - B2 = {2'b01, d[11:6]}
  - B3 = {3'b100, d[16:12]}
- Per byte (8N1): start bit 0, then data bits 0..7 LSB first, then stop bit 1. Each bit is held for exactly BAUD_BIT_PERIOD cycles.
- Bytes go out back-to-back with no idle between B1, B2 and B3.
- FSM, with a bit index 0..9 inside each SEND state:
  - IDLE -> SEND_B1 on transfer.
  - SEND_B1 -> SEND_B2 -> SEND_B3, each after its stop bit completes.
  - SEND_B3 -> IDLE after the stop bit completes (or -> GAP when the optional feature is compiled in).
  - GAP -> IDLE after GAP_BITS bit periods.
- Latency:
  - Start bit of B1 drives tx_wire_out starting the cycle after the accept edge.
  - A frame is 30 * BAUD_BIT_PERIOD cycles.
  - ready_out returns to 1 in the cycle immediately after the final stop-bit period.
- Back-to-back: if valid_in is held high, the next accept happens the first cycle ready_out = 1, so the next start bit follows the previous stop bit after one idle-high cycle.
- busy_out = 1 from the cycle after accept until the return to IDLE.
- tx_wire_out is registered, so the line is glitch-free.
- Counter width is sized to clog2(BAUD_BIT_PERIOD). The counter wraps to 0 at BAUD_BIT_PERIOD-1.

Optional Feature:
- Macro: INTER_FRAME_GAP_EN.
- Defined: after the B3 stop bit the FSM enters GAP and holds tx_wire_out = 1 for GAP_BITS * BAUD_BIT_PERIOD cycles. ready_out stays 0 and busy_out stays 1 during GAP. This gives the receiver extra resynchronisation margin.
- Not defined: the GAP state and its counter are absent, and SEND_B3 -> IDLE directly.

Test Plan:
All scenarios use INPUT_CLOCK_FREQ=16, BAUD_RATE=1, so 16 cycles per bit.
1. Send 17'h12345 -> line decodes to bytes 0x05, 0x4D, 0x92. ready_out is low for 480 cycles, then returns high.
2. Send 17'h1FFFF, then 17'h00000 with valid_in held high -> bytes 0x3F, 0x7F, 0x9F, then 0x00, 0x40, 0x80. The second start bit follows the first frame's last stop bit after exactly 1 idle cycle.
3. Toggle valid_in with varying data while busy -> no extra transfers. Only the first word is transmitted.
4. Pull rst_in low at cycle 200 of a frame -> tx_wire_out = 1 and busy_out = 0 with no clock edge. ready_out = 1 one edge after release. A new word then sends cleanly.
5. Feed a loopback into the 3-byte receive assembler at 200 MHz / 115200 with random words -> every received word equals the sent word.
6. With INTER_FRAME_GAP_EN and GAP_BITS=2, send two frames back-to-back -> 32 extra idle-high cycles between frames, with busy_out = 1 throughout the gap.
